instr_fetch_queue: RTL

Instruction fetch queue upstream of the five-stage MIPS pipeline: generates sequential word addresses to instruction memory over a req/ack handshake, buffers returned words with their PCs in a small FIFO, and presents them to the pipeline's IF/ID input under valid/ready. A taken-branch redirect from the pipeline's memory stage flushes the queue and restarts fetch at the target, discarding any in-flight response.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/ifq_fifo.sv | 67 ++++++
 rtl/instr_fetch_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS front end
//               (instruction fetch queue and its FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam int          PC_STEP          = 4;
   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch-control states: FETCH requests, FULL waits for a pop,
   // DISCARD waits out an abandoned request after a redirect.
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      FULL    = 2'd1,
      DISCARD = 2'd2
   } ifq_state_t;

   // Instruction addresses are word aligned; the low two bits are ignored.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Synchronous FIFO with push, pop and clear; head entry is
//               read straight from storage so it holds until popped.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [WIDTH-1:0]           o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Guard against overflow/underflow; a full FIFO may still push when popping.
   always_comb begin
      w_do_pop  = i_pop && (r_count != '0);
      w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
   end

   // Storage and pointer/count update; clear empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Sequential instruction fetcher with a small {pc, word} queue
//               feeding IF/ID; branch redirect flushes and restarts fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
   import mips_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        instr_pc,
   input  logic               instr_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   ifq_state_t        r_state;
   ifq_state_t        w_state_nxt;
   logic [31:0]       r_fetch_pc;
   logic [31:0]       w_fetch_pc_nxt;
   logic [31:0]       r_hold_addr;
   logic [31:0]       w_hold_addr_nxt;
   logic [CW-1:0]     w_count;
   logic [CW-1:0]     w_count_after;
   logic [63:0]       w_head;
   logic              w_push;
   logic              w_pop;
   logic              w_unused_pc_bits;

   assign w_unused_pc_bits = ^redirect_pc[1:0];

   // Request/address drive; reset forces the request low immediately.
   always_comb begin
      imem_req  = (r_state != FULL) && rst_n;
      imem_addr = (r_state == DISCARD) ? r_hold_addr : r_fetch_pc;
   end

   // Queue handshakes; a redirect suppresses both push and pop.
   always_comb begin
      w_push        = (r_state == FETCH) && imem_ack && !redirect;
      w_pop         = instr_valid && instr_ready && !redirect;
      w_count_after = w_count + CW'(w_push) - CW'(w_pop);
   end

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({r_fetch_pc, imem_rdata}),
      .i_pop   (w_pop),
      .i_clear (redirect),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign instr_valid = (w_count != '0);
   assign instr_pc    = w_head[63:32];
   assign instr       = w_head[31:0];

   // Next-state, next fetch PC and abandoned-address capture.
   always_comb begin
      w_state_nxt     = r_state;
      w_fetch_pc_nxt  = r_fetch_pc;
      w_hold_addr_nxt = r_hold_addr;
      if (redirect) begin
         w_fetch_pc_nxt = align_pc(redirect_pc);
         if (imem_req && !imem_ack) begin
            // Request still outstanding: keep presenting it until acked.
            w_state_nxt     = DISCARD;
            w_hold_addr_nxt = imem_addr;
         end else begin
            w_state_nxt = FETCH;
         end
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ack) begin
                  w_fetch_pc_nxt = r_fetch_pc + 32'(PC_STEP);
                  if (w_count_after == CW'(DEPTH)) begin
                     w_state_nxt = FULL;
                  end
               end
            end
            FULL: begin
               if (w_pop) begin
                  w_state_nxt = FETCH;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  w_state_nxt = FETCH;
               end
            end
            default: w_state_nxt = FETCH;
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FETCH;
         r_fetch_pc  <= RESET_PC;
         r_hold_addr <= RESET_PC;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_hold_addr <= w_hold_addr_nxt;
      end
   end

endmodule
`default_nettype wire
